memory_port_arbiter: RTL

//   Shares the 16-bit memory FIFO between NUM_REQ producers and one consumer.
//   - Round-robin write arbitration with a bounded burst per owner.
//   - Tracks FIFO occupancy internally and never issues a write to a full FIFO or a read from an empty one.
//   - Sits directly in front of the memory block and drives its w, r and data_in pins.

---
 rtl/memory_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// Round-robin write arbiter with bounded bursts in front of a FIFO memory.
// Tracks occupancy, drives registered memory strobes and flags protocol errors.
//
//   state | meaning
//   IDLE  | no owner; grant the first requester after ptr when space exists
//   BURST | owner holds the port until it drops req or burst_cnt reaches MAX_BURST
module memory_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_W-1:0]     din,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd_req,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          mem_w,
    output logic                          mem_r,
    output logic [DATA_W-1:0]             mem_data_in,
    input  logic [DATA_W-1:0]             mem_data_out,
    input  logic                          mem_empty,
    input  logic                          mem_full,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int BW    = $clog2(MAX_BURST+1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [BW-1:0]    MAX_B   = BW'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(NUM_REQ-1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    owner, owner_nxt;
    logic [BW-1:0]       burst_cnt, burst_nxt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                grant;
    logic                space;
    logic                rd_issue;
    logic [IDX_W:0]      pick_idle, pick_rel;
    logic [DATA_W-1:0]   wr_word;

    // Nearest set bit after 'last' going upward with wrap; 'last' itself is checked last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_REQ;
            if (r[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    assign space     = (count < DEPTH_C);
    assign rd_issue  = rd_req && (count != '0);
    assign pick_idle = rr_pick(req, ptr);
    // Scanning from owner+1 leaves the owner as the final candidate, so it only wins when alone.
    assign pick_rel  = rr_pick(req, owner);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        grant     = 1'b0;
        gnt_idx   = owner;
        case (state)
            IDLE: begin
                if (space && pick_idle[IDX_W]) begin
                    grant     = 1'b1;
                    gnt_idx   = pick_idle[IDX_W-1:0];
                    owner_nxt = pick_idle[IDX_W-1:0];
                    burst_nxt = BW'(1);
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (!space) begin
                    state_nxt = BURST;
                end else if (req[owner] && (burst_cnt < MAX_B)) begin
                    grant     = 1'b1;
                    burst_nxt = burst_cnt + 1'b1;
                end else begin
                    ptr_nxt = owner;
                    if (pick_rel[IDX_W]) begin
                        grant     = 1'b1;
                        gnt_idx   = pick_rel[IDX_W-1:0];
                        owner_nxt = pick_rel[IDX_W-1:0];
                        burst_nxt = BW'(1);
                    end else begin
                        burst_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset gates the combinational grant so it reads 0 while rst is low.
    assign gnt     = (grant && rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign wr_word = din[gnt_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= LAST_I;
            owner       <= '0;
            burst_cnt   <= '0;
            count       <= '0;
            mem_w       <= 1'b0;
            mem_r       <= 1'b0;
            mem_data_in <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            err         <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            mem_w     <= grant;
            if (grant) mem_data_in <= wr_word;
            mem_r     <= rd_issue;
            rd_valid  <= mem_r;
            if (mem_r) rd_data <= mem_data_out;
            if (grant && !rd_issue)      count <= count + 1'b1;
            else if (!grant && rd_issue) count <= count - 1'b1;
            err <= err | (mem_w & mem_full) | (mem_r & mem_empty);
        end
    end

endmodule
